operand_rr_arbiter: RTL and testbench
=====================================

Name: operand_rr_arbiter

Overview:
- Shares the single 8-bit two-operand bfm datapath (A_s/B_s in, res_o out) between two independent stimulus requesters.
- Round-robin arbitration, at most one operand pair issued per clock.
- Tracks in-flight operations through the datapath's fixed latency and routes each result back to the requester that issued it.
- Sits between the stimulus generators (DPI-fed byte streams) and the bfm instance inside the top-level wrapper.

Parameters:
- LAT, 1, clocks from dp_a_o/dp_b_o update to the corresponding dp_res_i being valid; legal range 1..8.
- CNT_W, 32, width of the issue counters.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- enable_i  input  1  issue enable; when low, no new grants, in-flight results still return.
- req0_valid_i  input  1  requester 0 has an operand pair.
- req0_a_i  input  8  requester 0 operand A.
- req0_b_i  input  8  requester 0 operand B.
- req0_ready_o  output  1  requester 0 pair accepted this cycle.
- req1_valid_i  input  1  requester 1 has an operand pair.
- req1_a_i  input  8  requester 1 operand A.
- req1_b_i  input  8  requester 1 operand B.
- req1_ready_o  output  1  requester 1 pair accepted this cycle.
- dp_a_o  output  8  to bfm A_s.
- dp_b_o  output  8  to bfm B_s.
- dp_res_i  input  8  from bfm res_o.
- rsp0_valid_o  output  1  rsp_data_o belongs to requester 0.
- rsp1_valid_o  output  1  rsp_data_o belongs to requester 1.
- rsp_data_o  output  8  returned result.
- busy_o  output  1  at least one operation in flight.
- issued0_o  output  CNT_W  pairs accepted from requester 0.
- issued1_o  output  CNT_W  pairs accepted from requester 1.

Behaviour:
- Reset values:
  - dp_a_o, dp_b_o, rsp_data_o = 0.
  - rsp0_valid_o, rsp1_valid_o, busy_o = 0.
  - issued0_o, issued1_o = 0.
  - Last-grant pointer = 1, so requester 0 wins the first contention.
  - Tag pipeline cleared.
- Grant (combinational from current inputs and pointer):
  - No grant if enable_i = 0.
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester not granted last.
  - reqN_ready_o = 1 exactly when requester N is granted. Handshake is valid & ready; requesters must hold a, b and valid stable until ready.
- Issue, on the grant edge:
  - dp_a_o/dp_b_o <= granted pair.
  - Pointer <= granted id.
  - issuedN_o increments, wrapping modulo 2^CNT_W.
  - Tag pipeline stage 0 <= {valid = 1, id = granted}.
- No grant: dp_a_o/dp_b_o hold their last value; stage 0 <= valid = 0.
- Tag pipeline: LAT stages shifted every clock. When the last stage is valid, on that edge:
  - rsp_data_o <= dp_res_i.
  - rspN_valid_o <= 1 for the tagged id, for one cycle.
  - Otherwise both valid outputs are 0 and rsp_data_o holds.
- Total latency: handshake edge T -> dp_a_o/dp_b_o at T+1 -> response valid at T+1+LAT. Throughput is 1 per clock; back-to-back responses alternate ids under contention.
- busy_o is registered: 1 when any tag stage holds a valid entry after the edge.
- enable_i falling mid-stream:
  - Accepted operations still complete.
  - No ready asserted while low.
  - Pointer unchanged.
- reset_i mid-operation:
  - All in-flight tags dropped; no response for them.
  - Counters cleared.
  - reset_i dominates any same-cycle grant: no ready asserted while reset_i = 1.
- Requester deasserts valid without a handshake: no effect, no counter change.

Test Plan:
- Reset, enable_i = 1, LAT = 1, only req0 valid with pairs (3,5), (7,9) back-to-back -> req0_ready_o high 2 cycles, dp_a_o = 3 then 7, rsp0_valid_o pulses 2 consecutive cycles with the bfm results, issued0_o = 2, rsp1_valid_o never high.
- Both requesters continuously valid for 6 cycles -> grants 0,1,0,1,0,1; issued0_o = issued1_o = 3; response ids alternate in the same order.
- LAT = 4, single req1 pair (0xFF,0x01) -> dp_a_o = 0xFF one cycle after the handshake, rsp1_valid_o exactly 4 cycles later, busy_o high for 4 cycles then 0.
- Both valid, enable_i dropped after 2 grants for 3 cycles -> no ready during the low window, 2 responses still delivered, arbitration resumes with the requester not granted last.
- reset_i pulsed 1 cycle while 3 operations are in flight (LAT = 4) -> no rsp valid afterward, busy_o = 0, counters = 0, next contention granted to requester 0.
- CNT_W = 4, 17 accepted pairs from req0 -> issued0_o wraps to 1.

Source files
------------

// File: rtl/operand_rr_arbiter.sv
// operand_rr_arbiter
//   Shares one two-operand 8-bit datapath between two requesters with
//   round-robin arbitration (one pair per clock), and routes each result
//   back to its issuer after the datapath's fixed latency LAT.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   enable_i                issue enable (in-flight results still return)
//   reqN_valid/a/b_i        requester N operand pair
//   reqN_ready_o            requester N pair accepted this cycle
//   dp_a_o, dp_b_o          operands to the datapath
//   dp_res_i                datapath result, valid LAT clocks after issue
//   rspN_valid_o            rsp_data_o belongs to requester N
//   rsp_data_o              returned result
//   busy_o                  at least one operation in flight
//   issuedN_o               pairs accepted from requester N (wrapping)
module operand_rr_arbiter #(
    parameter int LAT   = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             req0_valid_i,
    input  logic [7:0]       req0_a_i,
    input  logic [7:0]       req0_b_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [7:0]       req1_a_i,
    input  logic [7:0]       req1_b_i,
    output logic             req1_ready_o,
    output logic [7:0]       dp_a_o,
    output logic [7:0]       dp_b_o,
    input  logic [7:0]       dp_res_i,
    output logic             rsp0_valid_o,
    output logic             rsp1_valid_o,
    output logic [7:0]       rsp_data_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] issued0_o,
    output logic [CNT_W-1:0] issued1_o
);

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_gnt;
    logic             r_last;          // id granted most recently
    logic [LAT-1:0]   r_vld_pipe;      // tag valid per in-flight stage
    logic [LAT-1:0]   r_id_pipe;       // tag id per in-flight stage
    logic [LAT-1:0]   w_vld_nxt;
    logic [LAT-1:0]   w_id_nxt;
    logic [7:0]       r_dp_a;
    logic [7:0]       r_dp_b;
    logic [7:0]       r_rsp_data;
    logic             r_rsp0;
    logic             r_rsp1;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Reset blocks grants so no handshake completes on a reset edge.
    always_comb begin
        w_gnt0 = enable_i && !reset_i && req0_valid_i && (!req1_valid_i || r_last);
        w_gnt1 = enable_i && !reset_i && req1_valid_i && (!req0_valid_i || !r_last);
    end

    assign w_gnt = w_gnt0 || w_gnt1;

    // Next tag-pipeline contents; busy is derived from this so it reflects
    // the state after the edge.
    always_comb begin
        w_vld_nxt    = '0;
        w_id_nxt     = '0;
        w_vld_nxt[0] = w_gnt;
        w_id_nxt[0]  = w_gnt1;
        for (int i = 1; i < LAT; i++) begin
            w_vld_nxt[i] = r_vld_pipe[i-1];
            w_id_nxt[i]  = r_id_pipe[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_last     <= 1'b1;
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
            r_dp_a     <= '0;
            r_dp_b     <= '0;
            r_rsp_data <= '0;
            r_rsp0     <= 1'b0;
            r_rsp1     <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            if (w_gnt) begin
                r_dp_a <= w_gnt1 ? req1_a_i : req0_a_i;
                r_dp_b <= w_gnt1 ? req1_b_i : req0_b_i;
                r_last <= w_gnt1;
            end
            if (w_gnt0) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_gnt1) r_cnt1 <= r_cnt1 + CNT_W'(1);
            r_vld_pipe <= w_vld_nxt;
            r_id_pipe  <= w_id_nxt;
            r_busy     <= |w_vld_nxt;
            r_rsp0     <= r_vld_pipe[LAT-1] && !r_id_pipe[LAT-1];
            r_rsp1     <= r_vld_pipe[LAT-1] &&  r_id_pipe[LAT-1];
            if (r_vld_pipe[LAT-1]) r_rsp_data <= dp_res_i;
        end
    end

    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;
    assign dp_a_o       = r_dp_a;
    assign dp_b_o       = r_dp_b;
    assign rsp0_valid_o = r_rsp0;
    assign rsp1_valid_o = r_rsp1;
    assign rsp_data_o   = r_rsp_data;
    assign busy_o       = r_busy;
    assign issued0_o    = r_cnt0;
    assign issued1_o    = r_cnt1;

endmodule

// File: tb/tb_operand_rr_arbiter.sv
module tb_operand_rr_arbiter;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic       rst = 1'b1, en = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       started = 1'b0;

    // DUT 1: LAT=1, CNT_W=32
    logic        rdy0_1, rdy1_1, rv0_1, rv1_1, busy_1;
    logic [7:0]  dpa_1, dpb_1, rsp_1, res_1;
    logic [31:0] iss0_1, iss1_1;
    // DUT 4: LAT=4, CNT_W=4
    logic        rdy0_4, rdy1_4, rv0_4, rv1_4, busy_4;
    logic [7:0]  dpa_4, dpb_4, rsp_4, res_4;
    logic [3:0]  iss0_4, iss1_4;

    operand_rr_arbiter #(.LAT(1), .CNT_W(32)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .enable_i(en),
        .req0_valid_i(v0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(rdy0_1),
        .req1_valid_i(v1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(rdy1_1),
        .dp_a_o(dpa_1), .dp_b_o(dpb_1), .dp_res_i(res_1),
        .rsp0_valid_o(rv0_1), .rsp1_valid_o(rv1_1), .rsp_data_o(rsp_1),
        .busy_o(busy_1), .issued0_o(iss0_1), .issued1_o(iss1_1)
    );

    operand_rr_arbiter #(.LAT(4), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .reset_i(rst), .enable_i(en),
        .req0_valid_i(v0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(rdy0_4),
        .req1_valid_i(v1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(rdy1_4),
        .dp_a_o(dpa_4), .dp_b_o(dpb_4), .dp_res_i(res_4),
        .rsp0_valid_o(rv0_4), .rsp1_valid_o(rv1_4), .rsp_data_o(rsp_4),
        .busy_o(busy_4), .issued0_o(iss0_4), .issued1_o(iss1_4)
    );

    // Datapath stand-ins computing a+b: LAT=1 is combinational,
    // LAT=4 adds three register stages.
    logic [7:0] bp [3];
    assign res_1 = dpa_1 + dpb_1;
    always @(posedge clk) begin
        bp[0] <= dpa_4 + dpb_4;
        bp[1] <= bp[0];
        bp[2] <= bp[1];
    end
    assign res_4 = bp[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // reference model state
    exp_t        q1[$], q4[$];
    logic        m_last = 1'b1;
    logic [31:0] m_cnt0 = '0, m_cnt1 = '0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [7:0]  m_hist = '0;   // grant history, newest in bit 0

    task automatic tick(output logic g0, output logic g1);
        logic e0, e1;
        exp_t x;
        #1;
        e0 = !rst && en && v0 && (!v1 || m_last);
        e1 = !rst && en && v1 && (!v0 || !m_last);
        chk("rdy0_l1", rdy0_1, e0);
        chk("rdy1_l1", rdy1_1, e1);
        chk("rdy0_l4", rdy0_4, e0);
        chk("rdy1_l4", rdy1_4, e1);
        if (e0 || e1) begin
            x.id   = e1;
            x.data = e1 ? a1 + b1 : a0 + b0;
            x.cyc  = cyc + 2;
            q1.push_back(x);
            x.cyc  = cyc + 5;
            q4.push_back(x);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
            m_a = '0; m_b = '0; m_hist = '0;
            q1.delete(); q4.delete();
        end else begin
            if (e0 || e1) begin
                m_last = e1;
                m_a    = e1 ? a1 : a0;
                m_b    = e1 ? b1 : b0;
            end
            if (e0) m_cnt0++;
            if (e1) m_cnt1++;
            m_hist = {m_hist[6:0], e0 || e1};
        end
        chk("dpa_l1", dpa_1, m_a);
        chk("dpb_l1", dpb_1, m_b);
        chk("dpa_l4", dpa_4, m_a);
        chk("dpb_l4", dpb_4, m_b);
        chk("iss0_l1", iss0_1, m_cnt0);
        chk("iss1_l1", iss1_1, m_cnt1);
        chk("iss0_l4", iss0_4, m_cnt0[3:0]);
        chk("iss1_l4", iss1_4, m_cnt1[3:0]);
        chk("busy_l1", busy_1, m_hist[0]);
        chk("busy_l4", busy_4, |m_hist[3:0]);
        g0 = e0;
        g1 = e1;
    endtask

    // new operands for whichever requester just handshook
    task automatic adv(input logic g0, input logic g1);
        if (g0) begin a0 = 8'($urandom); b0 = 8'($urandom); end
        if (g1) begin a1 = 8'($urandom); b1 = 8'($urandom); end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            chk("rsp_both_l1", rv0_1 & rv1_1, 0);
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                chk("rsp_late_l1", cyc, q1[0].cyc);
                void'(q1.pop_front());
            end
            if (rv0_1 || rv1_1) begin
                if (q1.size() == 0) chk("rsp_unexp_l1", {rv1_1, rv0_1}, 0);
                else begin
                    e = q1.pop_front();
                    chk("rsp_id_l1", rv1_1, e.id);
                    chk("rsp_data_l1", rsp_1, e.data);
                    chk("rsp_cyc_l1", cyc, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            chk("rsp_both_l4", rv0_4 & rv1_4, 0);
            while (q4.size() > 0 && q4[0].cyc < cyc) begin
                chk("rsp_late_l4", cyc, q4[0].cyc);
                void'(q4.pop_front());
            end
            if (rv0_4 || rv1_4) begin
                if (q4.size() == 0) chk("rsp_unexp_l4", {rv1_4, rv0_4}, 0);
                else begin
                    e = q4.pop_front();
                    chk("rsp_id_l4", rv1_4, e.id);
                    chk("rsp_data_l4", rsp_4, e.data);
                    chk("rsp_cyc_l4", cyc, e.cyc);
                end
            end
        end
    end

    task automatic do_reset();
        logic g0, g1;
        rst = 1'b1;
        tick(g0, g1);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        logic g0, g1;
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < n; i++) tick(g0, g1);
    endtask

    initial begin
        logic g0, g1;
        rst = 1'b1;
        tick(g0, g1);
        started = 1'b1;
        tick(g0, g1);
        chk("rst_rsp0", rv0_1 | rv0_4, 0);
        chk("rst_data", rsp_1 | rsp_4, 0);
        rst = 1'b0;
        en  = 1'b1;

        // req0 alone, two back-to-back pairs
        v0 = 1'b1; a0 = 8'd3; b0 = 8'd5;
        tick(g0, g1);
        chk("t1_g0a", g0, 1);
        chk("t1_dpa0", dpa_1, 3);
        a0 = 8'd7; b0 = 8'd9;
        tick(g0, g1);
        chk("t1_g0b", g0, 1);
        chk("t1_dpa1", dpa_1, 7);
        idle(6);
        chk("t1_cnt", iss0_1, 2);

        // full contention from a fresh pointer
        do_reset();
        v0 = 1'b1; v1 = 1'b1;
        a0 = 8'h10; b0 = 8'h01; a1 = 8'h20; b1 = 8'h02;
        for (int i = 0; i < 6; i++) begin
            tick(g0, g1);
            chk("t2_gnt", {g1, g0}, (i % 2) ? 2'b10 : 2'b01);
            adv(g0, g1);
        end
        idle(6);
        chk("t2_cnt0", iss0_1, 3);
        chk("t2_cnt1", iss1_1, 3);

        // single req1 pair through the LAT=4 path
        v1 = 1'b1; a1 = 8'hFF; b1 = 8'h01;
        tick(g0, g1);
        v1 = 1'b0;
        chk("t3_gnt", g1, 1);
        chk("t3_dpa", dpa_4, 8'hFF);
        chk("t3_busy0", busy_4, 1);
        for (int i = 1; i <= 4; i++) begin
            tick(g0, g1);
            chk("t3_busy", busy_4, i < 4);
            chk("t3_rsp1", rv1_4, i == 4);
        end
        idle(2);

        // enable dropped after two grants
        do_reset();
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 2; i++) begin tick(g0, g1); adv(g0, g1); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(g0, g1);
            chk("t4_noready", rdy0_1 | rdy1_1 | g0 | g1, 0);
        end
        en = 1'b1;
        tick(g0, g1);
        chk("t4_resume", {g1, g0}, 2'b01);
        adv(g0, g1);
        idle(6);

        // reset while three operations are in flight
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(g0, g1); adv(g0, g1); end
        rst = 1'b1;
        tick(g0, g1);
        chk("t5_rst_rdy", rdy0_1 | rdy1_1 | rdy0_4 | rdy1_4, 0);
        rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(g0, g1);
            chk("t5_norsp", rv0_1 | rv1_1 | rv0_4 | rv1_4, 0);
        end
        chk("t5_busy", busy_4, 0);
        chk("t5_cnt", iss0_4 + iss1_4, 0);
        v0 = 1'b1; v1 = 1'b1;
        tick(g0, g1);
        chk("t5_first", {g1, g0}, 2'b01);
        adv(g0, g1);
        idle(6);

        // valid dropped without handshake leaves counters alone
        en = 1'b0; v0 = 1'b1;
        tick(g0, g1);
        v0 = 1'b0; en = 1'b1;
        tick(g0, g1);
        chk("t7_cnt", iss0_1, m_cnt0);

        // counter wrap on the 4-bit instance
        do_reset();
        v0 = 1'b1;
        for (int i = 0; i < 17; i++) begin tick(g0, g1); adv(g0, g1); end
        idle(6);
        chk("t6_wrap", iss0_4, 1);
        chk("t6_nowrap", iss0_1, 17);

        chk("q1_drained", q1.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
